// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions, mode encodings
// and the nibble-to-glyph table (gfedcba, active-high).
package seven_seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_HEX = 1'b1;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return HEX7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to seven-segment glyph (gfedcba, active-high).
module seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  assign o_segs = hex7(i_nibble);

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Multiplexed N-digit seven-segment driver with double-buffered inputs, per-digit enable,
// PWM brightness and a blanking guard band at the start of each digit slot.
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 200000,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned BRIGHT_BITS    = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic [8*NUM_DIGITS-1:0] raw_segs,
  input  logic [4*NUM_DIGITS-1:0] hex_value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]          P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]          P_GUARD = PW'(GUARD_CYCLES);
  localparam logic [DW-1:0]          D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_BITS-1:0] B_FULL  = '1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};

  typedef struct packed {
    logic                            mode;
    logic [NUM_DIGITS-1:0][7:0]      raw;
    logic [NUM_DIGITS-1:0][3:0]      hex;
    logic [NUM_DIGITS-1:0]           dp;
    logic [NUM_DIGITS-1:0]           en;
    logic [BRIGHT_BITS-1:0]          bright;
  } shadow_t;

  logic [PW-1:0]          r_p;
  logic [DW-1:0]          r_d;
  logic [BRIGHT_BITS-1:0] r_q;
  shadow_t                r_pend;
  shadow_t                r_act;
  logic [7:0]             r_seg;
  logic [NUM_DIGITS-1:0]  r_an;
  logic                   r_frame_tick;

  logic                   w_slot_end;
  logic                   w_wrap;
  logic                   w_pwm_on;
  logic                   w_lit;
  logic [6:0]             w_hex_segs;
  logic [7:0]             w_seg_val;
  logic [NUM_DIGITS-1:0]  w_an_onehot;

  assign w_slot_end = (r_p == P_LAST);
  assign w_wrap     = w_slot_end && (r_d == D_LAST);
  assign w_pwm_on   = (r_act.bright == B_FULL) || (r_q < r_act.bright);
  assign w_lit      = (r_p >= P_GUARD) && r_act.en[r_d] && w_pwm_on;

  seg_hex_decoder u_hex_decoder (
    .i_nibble (r_act.hex[r_d]),
    .o_segs   (w_hex_segs)
  );

  always_comb begin
    w_seg_val = r_act.raw[r_d];
    if (r_act.mode == MODE_HEX) begin
      w_seg_val         = {1'b0, w_hex_segs};
      w_seg_val[SEG_DP] = r_act.dp[r_d];
    end
  end

  always_comb begin
    w_an_onehot = '0;
    if (w_lit) w_an_onehot[r_d] = 1'b1;
  end

  // Scan position and PWM phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
      r_d <= '0;
      r_q <= '0;
    end else begin
      r_q <= r_q + 1'b1;
      if (w_slot_end) begin
        r_p <= '0;
        r_d <= w_wrap ? '0 : r_d + 1'b1;
      end else begin
        r_p <= r_p + 1'b1;
      end
    end
  end

  // Pending captures host writes; active only changes at frame boundaries so a frame is
  // never drawn from half-updated data. A load on the wrap cycle lands in the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_act  <= '0;
    end else begin
      if (load) begin
        r_pend.mode   <= mode;
        r_pend.raw    <= raw_segs;
        r_pend.hex    <= hex_value;
        r_pend.dp     <= dp;
        r_pend.en     <= digit_enable;
        r_pend.bright <= brightness;
      end
      if (w_wrap) r_act <= r_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg        <= (w_lit ? w_seg_val : 8'h00) ^ SEG_OFF;
      r_an         <= w_an_onehot ^ AN_OFF;
      r_frame_tick <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed-plus-random bench for seven_seg_scan_mux, checked against a cycle-count model.
module tb_seven_seg_scan_mux;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int BB    = 2;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [31:0] raw_segs;
  logic [15:0] hex_value;
  logic [3:0]  dp;
  logic [3:0]  digit_enable;
  logic [1:0]  brightness;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_seg_scan_mux #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (RD),
    .GUARD_CYCLES   (GC),
    .BRIGHT_BITS    (BB),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .raw_segs     (raw_segs),
    .hex_value    (hex_value),
    .dp           (dp),
    .digit_enable (digit_enable),
    .brightness   (brightness),
    .load         (load),
    .seg          (seg),
    .an           (an),
    .frame_tick   (frame_tick)
  );

  typedef struct packed {
    logic        mode;
    logic [31:0] raw;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [1:0]  br;
  } cfg_t;

  cfg_t       pend;
  cfg_t       act;
  int         t;
  int         total;
  int         bad;
  logic [6:0] hex_tab [16];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // One clock: predict the pins from elapsed cycle count, advance the model, compare.
  task automatic step(input string tag);
    int         p, d, q;
    bit         lit;
    logic [7:0] sv, exp_seg;
    logic [3:0] exp_an;
    logic       exp_tick;
    if (reset) begin
      exp_an = 4'hF; exp_seg = 8'hFF; exp_tick = 1'b0;
      pend = '0; act = '0; t = 0;
    end else begin
      p = t % RD; d = (t / RD) % N; q = t % 4;
      lit = (p >= GC) && act.en[d] && ((act.br == 2'd3) || (q < int'(act.br)));
      if (act.mode) sv = {act.dp[d], hex_tab[act.hex[4*d +: 4]]};
      else          sv = act.raw[8*d +: 8];
      exp_an   = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg  = lit ? ~sv : 8'hFF;
      exp_tick = ((t % FRAME) == FRAME - 1);
      if (exp_tick) act = pend;
      if (load) pend = '{mode, raw_segs, hex_value, dp, digit_enable, brightness};
      t++;
    end
    @(posedge clk);
    #1;
    chk({tag, ".an"}, {4'h0, an}, {4'h0, exp_an});
    chk({tag, ".seg"}, seg, exp_seg);
    chk({tag, ".tick"}, {7'h0, frame_tick}, {7'h0, exp_tick});
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input string tag);
    load = 1'b1;
    step(tag);
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step(tag);
      n++;
      seen = frame_tick;
    end
    total++;
    assert (seen)
    else begin
      bad++;
      $error("FAIL %s frame_tick got=0 exp=1 within %0d cycles", tag, 3 * FRAME);
    end
  endtask

  task automatic run_to_phase(input string tag, input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(tag);
  endtask

  initial begin
    int n;
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    total = 0; bad = 0; t = 0; pend = '0; act = '0;
    reset = 1'b1; load = 1'b0; mode = 1'b0; raw_segs = '0; hex_value = '0;
    dp = '0; digit_enable = '0; brightness = '0;

    run("reset", 3);
    reset = 1'b0;
    run("dark_after_reset", 40);

    // Hex 1234 at full brightness.
    mode = 1'b1; hex_value = 16'h1234; dp = 4'h0; digit_enable = 4'hF; brightness = 2'd3;
    do_load("hex_load");
    wait_tick("hex_wait", n);
    run("hex_guard", 2);
    chk("hex_guard_an", {4'h0, an}, 8'h0F);
    chk("hex_guard_seg", seg, 8'hFF);
    step("hex_d0");
    chk("hex_d0_an", {4'h0, an}, 8'h0E);
    chk("hex_d0_seg", seg, 8'h99);
    wait_tick("hex_period", n);
    chk("hex_period_len", 8'(n), 8'(FRAME - 3));
    wait_tick("hex_period2", n);
    chk("hex_period2_len", 8'(n), 8'(FRAME));

    // Raw mode, dp only on digit 1.
    mode = 1'b0; raw_segs = 32'h0000_8000;
    do_load("raw_load");
    wait_tick("raw_wait", n);
    run("raw_d1", RD + 3);
    chk("raw_d1_an", {4'h0, an}, 8'h0D);
    chk("raw_d1_seg", seg, 8'h7F);
    run("raw_rest", FRAME);

    mode = 1'b1; brightness = 2'd1;
    do_load("br1_load");
    wait_tick("br1_wait", n);
    run("br1", 2 * FRAME);
    brightness = 2'd0;
    do_load("br0_load");
    wait_tick("br0_wait", n);
    for (int i = 0; i < FRAME; i++) begin
      step("br0");
      chk("br0_dark", {4'h0, an}, 8'h0F);
    end

    // Load exactly on the wrap cycle.
    brightness = 2'd3; hex_value = 16'h1234;
    do_load("wrap_prep");
    wait_tick("wrap_prep_wait", n);
    run_to_phase("wrap_seek", FRAME - 1);
    hex_value = 16'hFFFF;
    do_load("wrap_load");
    run("wrap_old", RD - 1);
    chk("wrap_old_seg", seg, 8'h99);
    wait_tick("wrap_wait", n);
    run("wrap_new", GC + 1);
    chk("wrap_new_seg", seg, 8'h8E);
    run("wrap_new_rest", FRAME);

    digit_enable = 4'b0101;
    do_load("en_load");
    wait_tick("en_wait", n);
    for (int i = 0; i < FRAME; i++) begin
      step("en");
      chk("en_off", {6'h0, an[3], an[1]}, 8'h03);
    end
    wait_tick("en_period", n);
    chk("en_period_len", 8'(n), 8'(FRAME));

    for (int k = 0; k < 12; k++) begin
      mode = 1'($urandom); raw_segs = $urandom; hex_value = 16'($urandom);
      dp = 4'($urandom); digit_enable = 4'($urandom); brightness = 2'($urandom);
      if ($urandom_range(0, 3) != 0) do_load("rnd_load");
      run("rnd", $urandom_range(1, 40));
      raw_segs = $urandom; hex_value = 16'($urandom);
      run("rnd_noload", $urandom_range(1, 20));
    end

    // Reset in the middle of digit 2's slot.
    mode = 1'b1; hex_value = 16'h1234; digit_enable = 4'hF; brightness = 2'd3;
    do_load("rst_prep");
    wait_tick("rst_prep_wait", n);
    run_to_phase("rst_seek", 2 * RD + 4);
    reset = 1'b1;
    step("rst_mid");
    chk("rst_mid_an", {4'h0, an}, 8'h0F);
    chk("rst_mid_seg", seg, 8'hFF);
    chk("rst_mid_tick", {7'h0, frame_tick}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < FRAME + 8; i++) begin
      step("rst_dark");
      chk("rst_dark_an", {4'h0, an}, 8'h0F);
    end
    do_load("rst_reload");
    wait_tick("rst_reload_wait", n);
    run("rst_reload_run", FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
